hamming_decoder: RTL
====================

Name: hamming_decoder

Overview:
Downstream stage of the 8-bit Hamming encoder. Accepts 8-bit codewords (layout P4 D4 D3 D2 P3 D1 P2 P1, bit7..bit0), computes a 4-bit syndrome, corrects single-bit errors and flags double-bit errors. It is a 2-stage valid/ready pipeline with saturating error-statistics counters, and sits between the channel/storage model and the data consumer.

Parameters:
CNT_W, 8, width of each saturating error counter (legal range 2..16)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, asynchronous, active-low
in_valid  input  1  code_in is valid this cycle
in_ready  output  1  decoder can accept code_in this cycle
code_in  input  8  received codeword {P4,D4,D3,D2,P3,D1,P2,P1}
out_valid  output  1  data_out and flags are valid
out_ready  input  1  consumer accepts the output beat
data_out  output  4  decoded data {D4,D3,D2,D1}
syndrome  output  4  syndrome {c4,c3,c2,c1} of the output beat
sec  output  1  single error corrected on this beat
ded  output  1  double (uncorrectable) error on this beat
clr_cnt  input  1  synchronous clear of both counters
sec_cnt  output  CNT_W  count of corrected beats
ded_cnt  output  CNT_W  count of uncorrectable beats

Behaviour:
- Checks, with b = code_in:
  - c1 = b0^b2^b4^b6
  - c2 = b1^b2^b5^b6
  - c3 = b3^b4^b5^b6
  - c4 = b7^b2^b4^b5
- Syndrome-to-bit map (syndrome -> flipped bit): 0001->b0, 0010->b1, 1011->b2, 0100->b3, 1101->b4, 1110->b5, 0111->b6, 1000->b7. Every column has odd weight.
- Syndrome 0: no error; sec=0, ded=0.
- Odd-weight syndrome: flip the mapped bit; sec=1. A parity-bit flip leaves data unchanged but still sets sec=1.
- Even-weight non-zero syndrome: ded=1, sec=0. data_out carries the raw, uncorrected data bits.
- Stage 1 registers code_in and the syndrome. Stage 2 registers the corrected data, syndrome, sec and ded.
- Latency is exactly 2 cycles from input acceptance to out_valid when there is no backpressure.
- Handshake:
  - A transfer occurs when valid && ready.
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en.
  - Full throughput: 1 beat per cycle with out_ready held high.
  - in_ready must not combinationally depend on in_valid.
- While out_valid=1 and out_ready=0, data_out, syndrome, sec and ded hold stable. Beats are never dropped or duplicated.
- Counters:
  - sec_cnt / ded_cnt increment by 1 on an output transfer with sec / ded set.
  - Both saturate at all-ones with no wrap.
  - clr_cnt=1 forces both to 0 next cycle; clear wins over a simultaneous increment.
- Reset (async assert, sync release is the system's concern): out_valid=0, internal s1_valid=0, data_out=0, syndrome=0, sec=0, ded=0, sec_cnt=0, ded_cnt=0.
  - in_ready=1 in the first cycle after release.
  - In-flight beats are discarded on reset.
- code_in is ignored while in_valid=0. Stage registers hold their value when not enabled.

Optional Feature:
Macro HAMMING_DEC_CNT_EN.
- Defined: counters and clr_cnt are implemented as specified.
- Undefined: no counter logic is generated. sec_cnt and ded_cnt are tied to 0, clr_cnt is ignored, and the ports stay present.
- Datapath and handshake are identical in both builds.

Decomposition:
- Package hamming_pkg holds:
  - codeword bit-position constants: P1=0, P2=1, D1=2, P3=3, D2=4, D3=5, D4=6, P4=7
  - the 8 syndrome column constants
  - a syndrome-compute function, shared with the encoder
- One natural sub-module, hamming_syndrome_correct: combinational, takes code + syndrome and gives corrected data, sec and ded. It is instantiated between stage 1 and stage 2.

Test Plan:
- Clean codeword: code_in=8'h55, out_ready=1 -> 2 cycles later data_out=4'hB, syndrome=0, sec=0, ded=0.
- Single data error: code_in=8'h75 (b5 flipped) -> data_out=4'hB, syndrome=4'b1110, sec=1; sec_cnt 0->1.
- Single parity error and double error:
  - 8'hD5 (P4 flipped) -> data_out=4'hB, syndrome=4'b1000, sec=1.
  - 8'h74 (b0,b5 flipped) -> syndrome=4'b1111, ded=1, data_out=4'hF raw; ded_cnt increments.
- Backpressure: stream 8'h55, 8'h75, 8'h74, 8'h00 with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 beats are buffered, outputs hold stable, all 4 beats delivered in order with no loss or duplication.
- Saturation/clear: CNT_W=2, 5 corrupted beats -> sec_cnt stays at 3; clr_cnt pulsed together with a sec beat -> sec_cnt=0.
- Reset mid-stream: assert rstn=0 with 2 beats in flight -> out_valid=0 and counters=0 immediately; after release no stale beat appears and in_ready=1.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming (8,4) SEC-DED definitions: codeword bit positions, syndrome
// columns and the syndrome function also used by the encoder side.
package hamming_pkg;

  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D1 = 2;
  localparam int P3 = 3;
  localparam int D2 = 4;
  localparam int D3 = 5;
  localparam int D4 = 6;
  localparam int P4 = 7;

  // Syndrome {c4,c3,c2,c1} produced by a flip of each codeword bit.
  localparam logic [3:0] SYN_B0 = 4'b0001;
  localparam logic [3:0] SYN_B1 = 4'b0010;
  localparam logic [3:0] SYN_B2 = 4'b1011;
  localparam logic [3:0] SYN_B3 = 4'b0100;
  localparam logic [3:0] SYN_B4 = 4'b1101;
  localparam logic [3:0] SYN_B5 = 4'b1110;
  localparam logic [3:0] SYN_B6 = 4'b0111;
  localparam logic [3:0] SYN_B7 = 4'b1000;

  localparam logic [7:0][3:0] SYN_COL = {SYN_B7, SYN_B6, SYN_B5, SYN_B4,
                                         SYN_B3, SYN_B2, SYN_B1, SYN_B0};

  function automatic logic [3:0] calc_syndrome(input logic [7:0] b);
    calc_syndrome = {b[P4] ^ b[D1] ^ b[D2] ^ b[D3],
                     b[P3] ^ b[D2] ^ b[D3] ^ b[D4],
                     b[P2] ^ b[D1] ^ b[D3] ^ b[D4],
                     b[P1] ^ b[D1] ^ b[D2] ^ b[D4]};
  endfunction

endpackage

// File: rtl/hamming_syndrome_correct.sv
// Combinational correction: odd-weight syndrome flips the matching bit (sec),
// even-weight non-zero syndrome flags ded and passes the raw data through.
module hamming_syndrome_correct
  import hamming_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic [3:0] syn_i,
  output logic [3:0] data_o,
  output logic       sec_o,
  output logic       ded_o
);

  logic [7:0] fixed;

  always_comb begin
    fixed = code_i;
    sec_o = 1'b0;
    ded_o = 1'b0;
    if (syn_i != 4'b0000) begin
      if (^syn_i) begin
        sec_o = 1'b1;
        for (int i = 0; i < 8; i++) begin
          if (syn_i == SYN_COL[i]) fixed[i] = ~code_i[i];
        end
      end else begin
        ded_o = 1'b1;
      end
    end
  end

  assign data_o = {fixed[D4], fixed[D3], fixed[D2], fixed[D1]};

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage valid/ready Hamming SEC-DED decoder with saturating error counters.
// Counters exist only when HAMMING_DEC_CNT_EN is defined; otherwise they read 0.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic [3:0]       syndrome,
  output logic             sec,
  output logic             ded,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sec_cnt,
  output logic [CNT_W-1:0] ded_cnt
);

  logic       s1_valid_q;
  logic [7:0] s1_code_q;
  logic [3:0] s1_syn_q;
  logic       out_valid_q;
  logic [3:0] data_q;
  logic [3:0] syn_q;
  logic       sec_q;
  logic       ded_q;
  logic [3:0] fix_data;
  logic       fix_sec;
  logic       fix_ded;
  logic       s1_en;
  logic       s2_en;

  // Enables depend only on registered state and out_ready, never on in_valid.
  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= code_in;
        s1_syn_q  <= calc_syndrome(code_in);
      end
    end
  end

  hamming_syndrome_correct u_correct (
    .code_i (s1_code_q),
    .syn_i  (s1_syn_q),
    .data_o (fix_data),
    .sec_o  (fix_sec),
    .ded_o  (fix_ded)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      syn_q       <= '0;
      sec_q       <= 1'b0;
      ded_q       <= 1'b0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q <= fix_data;
        syn_q  <= s1_syn_q;
        sec_q  <= fix_sec;
        ded_q  <= fix_ded;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign syndrome  = syn_q;
  assign sec       = sec_q;
  assign ded       = ded_q;

`ifdef HAMMING_DEC_CNT_EN
  logic             out_fire;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;

  assign out_fire = out_valid_q && out_ready;

  // Clear has priority over a same-cycle increment; counts stick at all-ones.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (clr_cnt) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else begin
      if (out_fire && sec_q && (sec_cnt_q != {CNT_W{1'b1}})) sec_cnt_d = sec_cnt_q + 1'b1;
      if (out_fire && ded_q && (ded_cnt_q != {CNT_W{1'b1}})) ded_cnt_d = ded_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign sec_cnt = sec_cnt_q;
  assign ded_cnt = ded_cnt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign sec_cnt        = '0;
  assign ded_cnt        = '0;
`endif

endmodule
